// File: rtl/lsu.sv
// RV32I load/store unit: validates and formats one data-memory access at a time,
// holding the pipeline until memory acknowledges, then pulses a load/store completion.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        st_done,
  output logic        lsu_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        err_q, err_d;

  logic        legal, aligned, accept, reject;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata_rep;
  logic [31:0] ld_fmt;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [7:0]  rbyte [4];
  logic [15:0] rhalf [2];

  // Request decode: legality, alignment, byte enables and lane-replicated store data
  always_comb begin
    legal        = 1'b0;
    aligned      = 1'b0;
    ex_be        = 4'b0000;
    ex_wdata_rep = ex_wdata;
    if (ex_is_store) begin
      legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    end else begin
      legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
              (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    end
    case (ex_funct3[1:0])
      2'b00: begin
        aligned      = 1'b1;
        ex_be        = 4'b0001 << ex_addr[1:0];
        ex_wdata_rep = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        aligned      = ~ex_addr[0];
        ex_be        = ex_addr[1] ? 4'b1100 : 4'b0011;
        ex_wdata_rep = {2{ex_wdata[15:0]}};
      end
      default: begin
        aligned      = (ex_addr[1:0] == 2'b00);
        ex_be        = 4'b1111;
        ex_wdata_rep = ex_wdata;
      end
    endcase
    accept = (state_q == IDLE) && ex_valid && (ex_is_load ^ ex_is_store) && legal && aligned;
    reject = (state_q == IDLE) && ex_valid && (ex_is_load | ex_is_store) && !accept;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign rhalf[gi] = mem_rdata[16*gi +: 16];
    end
  endgenerate

  // Load result formatting uses the captured address lane and funct3
  always_comb begin
    sel_byte = rbyte[addr_q[1:0]];
    sel_half = rhalf[addr_q[1]];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_fmt = {24'h000000, sel_byte};
      3'b001:  ld_fmt = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_fmt = {16'h0000, sel_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    be_d      = be_q;
    we_d      = we_q;
    rd_d      = rd_q;
    ld_data_d = ld_data_q;
    ld_rd_d   = ld_rd_q;
    err_d     = reject;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = BUSY;
          addr_d   = ex_addr;
          wdata_d  = ex_wdata_rep;
          funct3_d = ex_funct3;
          be_d     = ex_be;
          we_d     = ex_is_store;
          rd_d     = ex_rd;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = RESP;
          if (!we_q) begin
            ld_data_d = ld_fmt;
            ld_rd_d   = rd_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      funct3_q  <= 3'b000;
      be_q      <= 4'b0000;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      ld_data_q <= 32'h0;
      ld_rd_q   <= 5'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      be_q      <= be_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      ld_data_q <= ld_data_d;
      ld_rd_q   <= ld_rd_d;
      err_q     <= err_d;
    end
  end

  assign stall     = accept || (state_q == BUSY);
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) && we_q;
  assign mem_be    = (state_q == BUSY) ? be_q : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign ld_valid  = (state_q == RESP) && !we_q;
  assign st_done   = (state_q == RESP) && we_q;
  assign ld_data   = ld_data_q;
  assign ld_rd     = ld_rd_q;
  assign lsu_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu, plus hand sequences for ack-in-idle,
// ex_* activity during an access, and reset in the middle of an access.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_valid, st_done, lsu_err;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;

  lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .st_done(st_done), .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          k;      // BUSY cycle (1-based) in which mem_ack is given
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] ldd;
  } vec_t;

  vec_t        vecs[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_ld = 32'h0;
  logic [4:0]  last_rd = 5'd0;

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input int k,
                              input logic err, input logic [3:0] be,
                              input logic [31:0] mwdata, input logic [31:0] ldd);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.k = k; v.err = err; v.be = be; v.mwdata = mwdata; v.ldd = ldd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    drive_ex(1'b1, v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    mem_ack = 1'b0;
    #1;
    chk({nm, " stall_at_issue"}, {31'b0, stall}, v.err ? 32'd0 : 32'd1);
    chk({nm, " req_at_issue"}, {31'b0, mem_req}, 32'd0);
    if (stall) stall_cnt++;
    @(posedge clk);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    if (v.err) begin
      #1;
      chk({nm, " lsu_err"}, {31'b0, lsu_err}, 32'd1);
      chk({nm, " err_req"}, {31'b0, mem_req}, 32'd0);
      chk({nm, " err_stall"}, {31'b0, stall}, 32'd0);
      chk({nm, " err_be"}, {28'b0, mem_be}, 32'd0);
      chk({nm, " err_ld_valid"}, {31'b0, ld_valid}, 32'd0);
      chk({nm, " err_ld_data_hold"}, ld_data, last_ld);
      @(negedge clk);
      #1;
      chk({nm, " err_single_pulse"}, {31'b0, lsu_err}, 32'd0);
      chk({nm, " err_req_after"}, {31'b0, mem_req}, 32'd0);
      $display("txn %s: error access addr=%h f3=%b ld=%b st=%b", nm, v.addr, v.f3, v.ld, v.st);
      return;
    end
    for (int c = 1; c <= v.k; c++) begin
      if (c > 1) @(negedge clk);
      mem_ack   = (c == v.k);
      mem_rdata = (c == v.k) ? v.rdata : 32'h0BAD0BAD;
      #1;
      chk({nm, " busy_req"}, {31'b0, mem_req}, 32'd1);
      chk({nm, " busy_we"}, {31'b0, mem_we}, {31'b0, v.st});
      chk({nm, " busy_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      chk({nm, " busy_be"}, {28'b0, mem_be}, {28'b0, v.be});
      if (v.st) chk({nm, " busy_wdata"}, mem_wdata, v.mwdata);
      chk({nm, " busy_no_pulse"}, {29'b0, ld_valid, st_done, lsu_err}, 32'd0);
      if (stall) stall_cnt++;
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    if (v.ld) begin
      last_ld = v.ldd;
      last_rd = v.rd;
    end
    chk({nm, " resp_stall"}, {31'b0, stall}, 32'd0);
    chk({nm, " resp_req"}, {31'b0, mem_req}, 32'd0);
    chk({nm, " resp_ld_valid"}, {31'b0, ld_valid}, {31'b0, v.ld});
    chk({nm, " resp_st_done"}, {31'b0, st_done}, {31'b0, v.st});
    chk({nm, " resp_ld_data"}, ld_data, last_ld);
    chk({nm, " resp_ld_rd"}, {27'b0, ld_rd}, {27'b0, last_rd});
    chk({nm, " stall_cycles"}, stall_cnt, v.k + 1);
    @(negedge clk);
    #1;
    chk({nm, " pulse_end"}, {30'b0, ld_valid, st_done}, 32'd0);
    $display("txn %s: %s addr=%h be=%b wdata=%h ld_data=%h rd=%0d ack_cycle=%0d",
             nm, v.st ? "store" : "load", mem_addr, v.be, v.mwdata, ld_data, ld_rd, v.k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);

    vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 1, 0, 4'hF, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0,        5'd6,  32'h80FFFFFF, 1, 0, 4'h8, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0,        5'd7,  32'h80FFFFFF, 1, 0, 4'h8, 32'h0,        32'h00000080));
    vecs.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0,        5'd8,  32'h80010000, 1, 0, 4'hC, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0,        5'd9,  32'h80010000, 2, 0, 4'hC, 32'h0,        32'h00008001));
    vecs.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0,        5'd10, 32'h00007F00, 2, 0, 4'h2, 32'h0,        32'h0000007F));
    vecs.push_back(mk(0, 1, 3'b000, 32'h201, 32'h12345678, 5'd0,  32'h0,        3, 0, 4'h2, 32'h78787878, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0,  32'h0,        1, 0, 4'hC, 32'hABCDABCD, 32'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 5'd0,  32'h0,        2, 0, 4'hF, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h102, 32'h0,        5'd3,  32'h0,        1, 1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h301, 32'h1111,     5'd0,  32'h0,        1, 1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h000, 32'h0,        5'd4,  32'h0,        1, 1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h000, 32'h0,        5'd0,  32'h0,        1, 1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h000, 32'h0,        5'd2,  32'h0,        1, 1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h100, 32'h0,        5'd11, 32'h1234FFFE, 1, 0, 4'h3, 32'h0,        32'hFFFFFFFE));
    vecs.push_back(mk(0, 1, 3'b000, 32'h203, 32'h000000A5, 5'd0,  32'h0,        1, 0, 4'h8, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h000, 32'h0,        5'd31, 32'h13579BDF, 4, 0, 4'hF, 32'h0,        32'h13579BDF));

    // Reset state
    #3;
    chk("reset_outputs", {24'b0, stall, mem_req, mem_we, ld_valid, st_done, lsu_err, 2'b0}, 32'd0);
    chk("reset_be", {28'b0, mem_be}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_ld_data", ld_data, 32'd0);
    chk("reset_ld_rd", {27'b0, ld_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // mem_ack in IDLE and a non-memory ex_valid are both ignored
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    drive_ex(1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 5'd1);
    #1;
    chk("idle_ack_stall", {31'b0, stall}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ack_quiet", {28'b0, mem_req, ld_valid, st_done, lsu_err}, 32'd0);
    end
    mem_ack = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    $display("txn idle_ack: ack and non-memory instruction in IDLE");

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // ex_* activity during BUSY and RESP must not disturb the access
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd7);
    @(posedge clk);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h900, 32'hFFFFFFFF, 5'd2);
    #1;
    chk("busy_ign_addr", mem_addr, 32'h500);
    chk("busy_ign_we", {31'b0, mem_we}, 32'd0);
    chk("busy_ign_be", {28'b0, mem_be}, 32'hF);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h11112222;
    #1;
    chk("busy_ign_req", {31'b0, mem_req}, 32'd1);
    chk("busy_ign_addr2", mem_addr, 32'h500);
    @(negedge clk);
    mem_ack = 1'b0;
    drive_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h900, 32'hFFFFFFFF, 5'd2);
    #1;
    last_ld = 32'h11112222;
    last_rd = 5'd7;
    chk("busy_ign_ld_valid", {31'b0, ld_valid}, 32'd1);
    chk("busy_ign_ld_data", ld_data, last_ld);
    chk("busy_ign_ld_rd", {27'b0, ld_rd}, {27'b0, last_rd});
    chk("resp_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #1;
    chk("resp_ign_no_req", {29'b0, mem_req, st_done, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("resp_ign_no_req2", {30'b0, mem_req, st_done}, 32'd0);
    $display("txn busy_ign: load 0x500 with ex_* toggling, ld_data=%h", ld_data);

    // Reset during the second BUSY cycle abandons the access
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd12);
    @(posedge clk);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rst_busy1_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    #1;
    chk("rst_busy2_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_req", {31'b0, mem_req}, 32'd0);
    chk("rst_async_stall", {31'b0, stall}, 32'd0);
    chk("rst_async_be", {28'b0, mem_be}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    last_ld = 32'h0;
    last_rd = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_no_pulse", {29'b0, ld_valid, st_done, mem_req}, 32'd0);
    end
    $display("txn rst_busy: load 0x600 abandoned by reset");
    run_vec(mk(1, 0, 3'b010, 32'h700, 32'h0, 5'd13, 32'h77778888, 1, 0, 4'hF, 32'h0, 32'h77778888), "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Parameters: none.

Interface
REQ-001 The block SHALL have a `clk` input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The block SHALL have an `rst` input, 1 bit: the reset, asynchronous and active-high.
REQ-003 The block SHALL have an `ex_valid` input, 1 bit: an execute-stage instruction is present.
REQ-004 The block SHALL have an `ex_is_load` input, 1 bit: the instruction is a load.
REQ-005 The block SHALL have an `ex_is_store` input, 1 bit: the instruction is a store.
REQ-006 The block SHALL have an `ex_funct3` input, 3 bits: the RV32I load/store width and sign code.
REQ-007 The block SHALL have an `ex_addr` input, 32 bits: the effective address, i.e. the ALU result (rs1 + imm).
REQ-008 The block SHALL have an `ex_wdata` input, 32 bits: the store data (rs2).
REQ-009 The block SHALL have an `ex_rd` input, 5 bits: the load destination register.
REQ-010 The block SHALL have a `stall` output, 1 bit: holds the upstream pipeline.
REQ-011 The block SHALL have a `mem_req` output, 1 bit: data-memory request.
REQ-012 The block SHALL have a `mem_we` output, 1 bit: write enable.
REQ-013 The block SHALL have a `mem_addr` output, 32 bits: the word-aligned address.
REQ-014 The block SHALL have a `mem_wdata` output, 32 bits: lane-replicated store data.
REQ-015 The block SHALL have a `mem_be` output, 4 bits: byte enables.
REQ-016 The block SHALL have a `mem_ack` input, 1 bit: memory completes the request.
REQ-017 The block SHALL have a `mem_rdata` input, 32 bits: the read word, valid while `mem_ack`=1.
REQ-018 The block SHALL have a `ld_valid` output, 1 bit: one-cycle pulse, load result ready.
REQ-019 The block SHALL have a `ld_data` output, 32 bits: the extended load result.
REQ-020 The block SHALL have a `ld_rd` output, 5 bits: the destination register of `ld_data`.
REQ-021 The block SHALL have a `st_done` output, 1 bit: one-cycle pulse, store completed.
REQ-022 The block SHALL have an `lsu_err` output, 1 bit: one-cycle pulse on a misaligned or illegal access.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-024 In IDLE, an accept SHALL occur when `ex_valid` is 1 and exactly one of `ex_is_load`/`ex_is_store` is 1, the `funct3` is legal and the address is aligned; on accept the block SHALL register the address, we, be, wdata, funct3 and rd, then go to BUSY.
REQ-025 Legal funct3 SHALL be 000, 001, 010, 100 and 101 for loads, and 000, 001 and 010 for stores.
REQ-026 Alignment SHALL be: halfword requires `addr[0]`=0; word requires `addr[1:0]`=00; byte is always aligned.
REQ-027 In IDLE, `ex_valid` with an illegal `funct3`, a misaligned address, or both `ex_is_load` and `ex_is_store` at 1 SHALL cause no memory access, `lsu_err`=1 on the next cycle, and the FSM remaining in IDLE.
REQ-028 In BUSY, `mem_req`=1 and all `mem_*` outputs SHALL be stable until `mem_ack`; on `mem_ack` the FSM SHALL go to RESP, and a load SHALL capture the formatted `mem_rdata` into `ld_data` and `ex_rd` into `ld_rd`.
REQ-029 In RESP, for one cycle, `ld_valid`=1 for a load or `st_done`=1 for a store, then the FSM SHALL return to IDLE.
REQ-030 `stall` SHALL be combinational and equal to (IDLE and accept) or BUSY; `stall` SHALL be 0 in RESP.
REQ-031 Minimum latency SHALL be: accept in cycle N, BUSY in N+1 with `mem_ack` possible in N+1, and `ld_valid`/`st_done` in N+2.
REQ-032 `mem_addr` SHALL equal {`addr[31:2]`, 2'b00}, and `mem_we` SHALL be 1 only for stores.
REQ-033 SB SHALL drive `mem_be` = 0001 << `addr[1:0]` and `mem_wdata` = the byte replicated 4 times.
REQ-034 SH SHALL drive `mem_be` = 0011 if `addr[1]`=0, else 1100, and `mem_wdata` = the halfword replicated twice.
REQ-035 SW SHALL drive `mem_be` = 1111 and `mem_wdata` = `ex_wdata`.
REQ-036 LB/LBU SHALL select byte lane `addr[1:0]`; LH/LHU SHALL select half lane `addr[1]`; LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-037 When not in BUSY, `mem_req`=0, `mem_be`=0000 and `mem_we`=0.
REQ-038 `mem_ack` outside BUSY SHALL be ignored.
REQ-039 `ex_*` inputs in BUSY or RESP SHALL be ignored.
REQ-040 `ld_data` and `ld_rd` SHALL hold their values until the next load completes.
REQ-041 The pulse outputs `ld_valid`, `st_done` and `lsu_err` SHALL never be 1 at the same time.

Reset
REQ-042 `rst`=1 SHALL immediately force IDLE and set `mem_req`, `mem_we`, `ld_valid`, `st_done` and `lsu_err` to 0, `mem_be` to 0000, and `mem_addr`, `mem_wdata`, `ld_data` and `ld_rd` to 0; `stall` SHALL follow from IDLE.
REQ-043 `rst` asserted in BUSY SHALL abandon the access: `mem_req` falls asynchronously, and no `ld_valid` or `st_done` is issued for that access.
REQ-044 After `rst` deasserts, the first accept SHALL be possible on the next rising edge.

Verification
REQ-045 LW at addr 0x100, `mem_rdata`=0xDEADBEEF, ack in the first BUSY cycle -> `mem_addr`=0x100, `mem_be`=1111, `ld_valid` at N+2, `ld_data`=0xDEADBEEF, `ld_rd` echoed.
REQ-046 LB at 0x103 with `mem_rdata`=0x80FF_FF_FF SHALL give `ld_data`=0xFFFFFF80; LBU at the same address SHALL give 0x00000080; LH at 0x102 with `mem_rdata`=0x8001_0000 SHALL give 0xFFFF8001.
REQ-047 SB at 0x201 with `wdata`=0x12345678 -> `mem_addr`=0x200, `mem_be`=0010, `mem_wdata`=0x78787878, `mem_we`=1; with `mem_ack` delayed 3 cycles, `stall` is held 4 cycles, then `st_done` pulses.
REQ-048 LW at 0x102 and SH at 0x301 -> `lsu_err` pulses once each, `mem_req` stays 0 and `stall` stays 0.
REQ-049 LW issued, `rst` pulsed in the second BUSY cycle -> `mem_req` drops immediately, no `ld_valid` is issued, and a following LW completes normally.
REQ-050 `mem_ack` asserted in IDLE, and `ex_valid` toggling during BUSY -> no state change and no extra request.
